// File: rtl/mdio_responder_pkg.sv
// Shared definitions for the Clause-22 MDIO responder: frame states, opcodes,
// register indices and the minimum preamble length.
package mdio_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    OP,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA
  } state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_CTRL     = 5'd0;
  localparam logic [4:0] REG_STATUS   = 5'd1;
  localparam logic [4:0] REG_ID_HI    = 5'd2;
  localparam logic [4:0] REG_ID_LO    = 5'd3;
  localparam logic [4:0] REG_SCRATCH0 = 5'd4;

  localparam int unsigned PREAMBLE_MIN = 32;

endpackage

// File: rtl/mdio_sync_edge.sv
// Brings mdc and mdio into the clk domain and flags each rising edge of mdc.
module mdio_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [1:0] mdc_sync;
  logic [1:0] mdio_sync;
  logic       mdc_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_sync  <= 2'b11;
      mdio_sync <= 2'b11;
      mdc_prev  <= 1'b1;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_i};
      mdc_prev  <= mdc_sync[1];
    end
  end

  assign mdc_rise = mdc_sync[1] & ~mdc_prev;
  assign mdio_s   = mdio_sync[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO slave: decodes frames on synchronized mdc edges and serves a
// small register file (control, status, PHY ID, four scratch registers).
module mdio_responder
  import mdio_responder_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [31:0] PHY_ID   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic [15:0] status_i,
  output logic [15:0] ctrl_o,
  output logic        soft_reset_o
);

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

  logic        mdc_rise;
  logic        mdio_s;

  state_e      state, state_next;
  logic [5:0]  pre_cnt, pre_cnt_next;
  logic [3:0]  bit_cnt, bit_cnt_next;
  logic [1:0]  op, op_next;
  logic [4:0]  addr, addr_next;
  logic [15:0] shift, shift_next;
  logic        drv_o, drv_o_next;
  logic        drv_t, drv_t_next;
  logic        soft_reset, soft_reset_next;
  logic [14:0] ctrl, ctrl_next;
  logic [15:0] scratch [4];
  logic [15:0] scratch_next [4];
  logic [15:0] rd_val;
  logic [15:0] wr_val;

  mdio_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s)
  );

  always_comb begin
    rd_val = 16'h0000;
    if (addr == REG_CTRL) begin
      rd_val = {1'b0, ctrl};
    end else if (addr == REG_STATUS) begin
      rd_val = status_i;
    end else if (addr == REG_ID_HI) begin
      rd_val = PHY_ID[31:16];
    end else if (addr == REG_ID_LO) begin
      rd_val = PHY_ID[15:0];
    end else if (addr[4:2] == REG_SCRATCH0[4:2]) begin
      rd_val = scratch[addr[1:0]];
    end
  end

  assign wr_val = {shift[14:0], mdio_s};

  always_comb begin
    state_next      = state;
    pre_cnt_next    = pre_cnt;
    bit_cnt_next    = bit_cnt;
    op_next         = op;
    addr_next       = addr;
    shift_next      = shift;
    drv_o_next      = drv_o;
    drv_t_next      = drv_t;
    soft_reset_next = 1'b0;
    ctrl_next       = ctrl;
    scratch_next    = scratch;
    if (mdc_rise) begin
      unique case (state)
        IDLE: begin
          if (mdio_s) begin
            if (pre_cnt < PRE_MIN) pre_cnt_next = pre_cnt + 6'd1;
          end else begin
            // A zero after a full preamble is the first start bit.
            if (pre_cnt >= PRE_MIN) state_next = START;
            pre_cnt_next = '0;
          end
        end
        START: begin
          bit_cnt_next = '0;
          state_next   = mdio_s ? OP : IDLE;
        end
        OP: begin
          op_next = {op[0], mdio_s};
          if (bit_cnt == 4'd0) begin
            bit_cnt_next = 4'd1;
          end else begin
            bit_cnt_next = '0;
            if (op_next == OP_READ || op_next == OP_WRITE) state_next = PHYAD;
            else state_next = IDLE;
          end
        end
        PHYAD, REGAD: begin
          addr_next = {addr[3:0], mdio_s};
          if (bit_cnt == 4'd4) begin
            bit_cnt_next = '0;
            if (state == REGAD) state_next = TA;
            else state_next = (addr_next == PHY_ADDR) ? REGAD : IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
        TA: begin
          if (bit_cnt == 4'd0) begin
            bit_cnt_next = 4'd1;
            if (op == OP_READ) begin
              shift_next = rd_val;
              drv_t_next = 1'b0;
              drv_o_next = 1'b0;
            end
          end else begin
            bit_cnt_next = '0;
            if (op == OP_READ) begin
              state_next = RDATA;
              drv_o_next = shift[15];
              shift_next = {shift[14:0], 1'b0};
            end else begin
              state_next = WDATA;
            end
          end
        end
        WDATA: begin
          shift_next = wr_val;
          if (bit_cnt == 4'd15) begin
            bit_cnt_next = '0;
            state_next   = IDLE;
            if (addr == REG_CTRL) begin
              ctrl_next       = wr_val[14:0];
              soft_reset_next = wr_val[15];
            end else if (addr[4:2] == REG_SCRATCH0[4:2]) begin
              scratch_next[addr[1:0]] = wr_val;
            end
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
        RDATA: begin
          if (bit_cnt == 4'd15) begin
            bit_cnt_next = '0;
            state_next   = IDLE;
            drv_t_next   = 1'b1;
            drv_o_next   = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
            drv_o_next   = shift[15];
            shift_next   = {shift[14:0], 1'b0};
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      op         <= '0;
      addr       <= '0;
      shift      <= '0;
      drv_o      <= 1'b0;
      drv_t      <= 1'b1;
      soft_reset <= 1'b0;
      ctrl       <= '0;
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
    end else begin
      state      <= state_next;
      pre_cnt    <= pre_cnt_next;
      bit_cnt    <= bit_cnt_next;
      op         <= op_next;
      addr       <= addr_next;
      shift      <= shift_next;
      drv_o      <= drv_o_next;
      drv_t      <= drv_t_next;
      soft_reset <= soft_reset_next;
      ctrl       <= ctrl_next;
      scratch    <= scratch_next;
    end
  end

  assign mdio_o       = drv_o;
  assign mdio_t       = drv_t;
  assign ctrl_o       = {1'b0, ctrl};
  assign soft_reset_o = soft_reset;

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: the PHY address this responder answers to.
REQ-002 SHALL have parameter PHY_ID, default 32'h0000_0000: value returned in reg2 (bits 31:16) and reg3 (bits 15:0).
REQ-003 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port mdc  input  1: management clock, asynchronous to clk, at most clk/8.
REQ-006 SHALL have port mdio_i  input  1: MDIO pad input, asynchronous.
REQ-007 SHALL have port mdio_o  output  1: MDIO drive value.
REQ-008 SHALL have port mdio_t  output  1: tristate enable; 1 = released, 0 = driving.
REQ-009 SHALL have port status_i  input  16: live value returned by reg1.
REQ-010 SHALL have port ctrl_o  output  16: current reg0 contents, with bit 15 always 0.
REQ-011 SHALL have port soft_reset_o  output  1: one-clk pulse when a write sets reg0 bit 15.

Function
REQ-012 SHALL pass mdc and mdio_i through 2-flop synchronizers; a bit event = detected rising edge of synchronized mdc; mdio sampled at that event.
REQ-013 SHALL use Clause-22 framing: preamble of >=32 ones, ST=01, OP (10 read, 01 write), PHYAD[4:0], REGAD[4:0], TA (2 bits), DATA[15:0], all MSB first.
REQ-014 SHALL use states IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA; a per-field bit counter advances once per bit event.
REQ-015 SHALL count consecutive ones in IDLE; a 0 with count<32 clears the count; a 0 with count>=32 is the first ST bit -> START.
REQ-016 SHALL return to IDLE with the preamble count cleared on: ST second bit != 1; OP 00 or 11; PHYAD != PHY_ADDR (evaluated at the 5th PHYAD bit).
REQ-017 SHALL, on a read, keep mdio_t=1 through TA bit 1, then drive mdio_t=0, mdio_o=0 for TA bit 2, then drive DATA[15] down to DATA[0].
REQ-018 SHALL make each drive change exactly 1 clk after the bit event that closes the preceding bit period.
REQ-019 SHALL latch read data at the bit event ending TA bit 1; status_i changes after that point SHALL not alter the frame.
REQ-020 SHALL set mdio_t=1 one clk after the bit event ending DATA[0], then return to IDLE with the preamble count 0.
REQ-021 SHALL ignore mdio_i during RDATA.
REQ-022 SHALL, on a write, not check TA, shift 16 bits, and commit in the clk after the 16th data event.
REQ-023 SHALL map registers: reg0 RW control; reg1 RO = status_i; reg2/reg3 RO = PHY_ID halves; reg4-reg7 RW scratch; REGAD 8-31 read 16'h0000, writes discarded.
REQ-024 SHALL, on a reg0 write with bit 15 = 1, pulse soft_reset_o in the commit clk, store bits 14:0, and read bit 15 as 0.
REQ-025 SHALL keep mdio_t=1 at all times except REQ-017 read phases.
REQ-026 SHALL start a frame only after a new >=32-one preamble, so back-to-back frames require their own preamble.

Reset
REQ-027 SHALL, on reset=1 at a clk edge: state IDLE, counters 0, mdio_t=1, mdio_o=0, reg0 and reg4-reg7 = 16'h0000, soft_reset_o=0, synchronizers = 1.
REQ-028 SHALL, on reset mid-frame, abandon the frame, perform no register write, and release the bus within 1 clk.

Structure
REQ-029 SHALL declare the state enum, OP_READ/OP_WRITE constants, register index constants, and PREAMBLE_MIN=32 in shared package mdio_responder_pkg.
REQ-030 SHALL instantiate one sub-module, mdio_sync_edge, containing the 2-flop synchronizers and mdc rising-edge detector; outputs mdc_rise and mdio_s.

Verification
REQ-031 Write reg4 = 16'hA5C3 at PHYAD 1, then read reg4 -> read returns 16'hA5C3; TA bit 1 released, TA bit 2 driven 0.
REQ-032 Read reg1 with status_i = 16'h796D, change status_i to 16'h0000 during DATA -> returns 16'h796D.
REQ-033 Frame to PHYAD 2 (PHY_ADDR = 1) -> mdio_t stays 1 for the whole frame; no register changes.
REQ-034 31-one preamble followed by a valid read -> ignored, mdio_t=1; repeat with 32 ones -> answered.
REQ-035 Write reg0 = 16'h8123 -> soft_reset_o high exactly 1 clk; ctrl_o = 16'h0123; read reg0 = 16'h0123.
REQ-036 Assert reset during RDATA bit 8 -> mdio_t=1 the next clk; reg4 unchanged; next valid frame answered normally.
